// File: rtl/memboard_pkg.sv
// memboard_pkg: shared widths and FIFO word layout for the ADC sample arbiter.
// FIFO word layout, MSB to LSB: {timestamp[TS_W], channel[CH_IDX_W], data[DATA_W]}.
package memboard_pkg;

  localparam int CH_IDX_W   = 8;
  localparam int TRIG_DIV_W = 16;

  localparam int FIFO_DATA_LSB = 0;

  function automatic int fifo_ch_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int fifo_ts_lsb(input int data_w);
    return data_w + CH_IDX_W;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant of one requester per cycle.
// Ports:
//   fpga_clk_i, rst_i  clock, asynchronous active-high reset
//   req_i       [N]    request vector
//   en_i               grant allowed this cycle
//   gnt_o       [N]    one-hot grant (all zero when gnt_valid_o=0)
//   gnt_valid_o        a grant was issued
//   gnt_idx_o          index of the granted requester
// The search starts at the pointer and wraps N-1 -> 0; the pointer moves
// to granted index + 1 after every grant and holds otherwise.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             fpga_clk_i,
  input  logic             rst_i,
  input  logic [N-1:0]     req_i,
  input  logic             en_i,
  output logic [N-1:0]     gnt_o,
  output logic             gnt_valid_o,
  output logic [IDX_W-1:0] gnt_idx_o
);

  logic [IDX_W-1:0] ptr_q;

  always_comb begin
    int j;
    j           = 0;
    gnt_o       = '0;
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    if (en_i) begin
      for (int k = 0; k < N; k++) begin
        j = int'(ptr_q) + k;
        if (j >= N) j = j - N;
        if (!gnt_valid_o && req_i[j]) begin
          gnt_valid_o = 1'b1;
          gnt_idx_o   = IDX_W'(j);
          gnt_o[j]    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge fpga_clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (gnt_valid_o) begin
      ptr_q <= (gnt_idx_o == IDX_W'(N - 1)) ? '0 : gnt_idx_o + IDX_W'(1);
    end
  end

endmodule

// File: rtl/adc_sample_arbiter.sv
// adc_sample_arbiter: timestamps per-channel ADC samples into holding slots
// and drains them round-robin into a FIFO; also generates periodic
// auto-trigger pulses.
// Ports:
//   fpga_clk_i, rst_i       clock, asynchronous active-high reset
//   timer_tick_i            timestamp increment strobe
//   en_i                    capture enable (pending slots drain regardless)
//   data_ready_is [N_CH]    per-channel sample strobes
//   data_is [N_CH*DATA_W]   channel samples, channel i at [i*DATA_W +: DATA_W]
//   trig_div_i, trig_mask_i auto-trigger period (0 = off) and channel mask
//   trig_os [N_CH]          trigger pulses
//   fifo_full_i             FIFO almost-full, blocks grants
//   fifo_wr_o, fifo_data_o  FIFO write strobe and word {ts, ch, data}
//   ovf_clr_i, ovf_os       clear / sticky per-channel overflow flags
//   busy_o                  any slot pending
//   drop_cnt_os [N_CH*8]    saturating dropped-sample counters, present only
//                           when ADC_ARB_DROP_CNT_EN is defined
module adc_sample_arbiter
  import memboard_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DATA_W = 32,
  parameter int TS_W   = 24
) (
  input  logic                          fpga_clk_i,
  input  logic                          rst_i,
  input  logic                          timer_tick_i,
  input  logic                          en_i,
  input  logic [N_CH-1:0]               data_ready_is,
  input  logic [N_CH*DATA_W-1:0]        data_is,
  input  logic [TRIG_DIV_W-1:0]         trig_div_i,
  input  logic [N_CH-1:0]               trig_mask_i,
  output logic [N_CH-1:0]               trig_os,
  input  logic                          fifo_full_i,
  output logic                          fifo_wr_o,
  output logic [TS_W+CH_IDX_W+DATA_W-1:0] fifo_data_o,
  input  logic                          ovf_clr_i,
  output logic [N_CH-1:0]               ovf_os,
  output logic                          busy_o
`ifdef ADC_ARB_DROP_CNT_EN
  ,
  output logic [N_CH*8-1:0]             drop_cnt_os
`endif
);

  localparam int WORD_W = TS_W + CH_IDX_W + DATA_W;
  localparam int IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CH_LSB = fifo_ch_lsb(DATA_W);
  localparam int TS_LSB = fifo_ts_lsb(DATA_W);

  logic [TS_W-1:0]       ts_q;
  logic [TRIG_DIV_W-1:0] div_cnt_q;
  logic [N_CH-1:0]       pending_q, pending_nxt, cap, load, ovf_set, gnt;
  logic                  gnt_valid;
  logic [IDX_W-1:0]      gnt_idx;
  logic [DATA_W-1:0]     slot_data_q [N_CH];
  logic [TS_W-1:0]       slot_ts_q   [N_CH];
  logic [WORD_W-1:0]     word;

  always_ff @(posedge fpga_clk_i or posedge rst_i) begin
    if (rst_i) ts_q <= '0;
    else if (timer_tick_i) ts_q <= ts_q + TS_W'(1);
  end

  // >= rather than == so a period shortened below the running count
  // restarts at the next comparison instead of counting through wrap.
  always_ff @(posedge fpga_clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_cnt_q <= '0;
      trig_os   <= '0;
    end else if (trig_div_i == '0) begin
      div_cnt_q <= '0;
      trig_os   <= '0;
    end else if (div_cnt_q >= trig_div_i) begin
      div_cnt_q <= '0;
      trig_os   <= trig_mask_i;
    end else begin
      div_cnt_q <= div_cnt_q + TRIG_DIV_W'(1);
      trig_os   <= '0;
    end
  end

  rr_arbiter #(.N(N_CH)) u_rr (
    .fpga_clk_i  (fpga_clk_i),
    .rst_i       (rst_i),
    .req_i       (pending_q),
    .en_i        (!fifo_full_i),
    .gnt_o       (gnt),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  // A slot being granted this cycle is free to take a new sample, since
  // its old contents are forwarded to the output register on the same edge.
  always_comb begin
    cap         = en_i ? data_ready_is : '0;
    load        = cap & (~pending_q | gnt);
    ovf_set     = cap & pending_q & ~gnt;
    pending_nxt = load | (pending_q & ~gnt);
  end

  always_comb begin
    word                           = '0;
    word[TS_LSB +: TS_W]           = slot_ts_q[gnt_idx];
    word[CH_LSB +: CH_IDX_W]       = CH_IDX_W'(gnt_idx);
    word[FIFO_DATA_LSB +: DATA_W]  = slot_data_q[gnt_idx];
  end

  always_ff @(posedge fpga_clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_CH; i++) begin
        slot_data_q[i] <= '0;
        slot_ts_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (load[i]) begin
          slot_data_q[i] <= data_is[i*DATA_W +: DATA_W];
          slot_ts_q[i]   <= ts_q;
        end
      end
    end
  end

  always_ff @(posedge fpga_clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q   <= '0;
      busy_o      <= 1'b0;
      ovf_os      <= '0;
      fifo_wr_o   <= 1'b0;
      fifo_data_o <= '0;
    end else begin
      pending_q <= pending_nxt;
      busy_o    <= |pending_nxt;
      ovf_os    <= (ovf_clr_i ? '0 : ovf_os) | ovf_set;
      fifo_wr_o <= gnt_valid;
      if (gnt_valid) fifo_data_o <= word;
    end
  end

`ifdef ADC_ARB_DROP_CNT_EN
  logic [7:0] drop_cnt_q [N_CH];

  always_ff @(posedge fpga_clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_CH; i++) drop_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (ovf_clr_i) drop_cnt_q[i] <= ovf_set[i] ? 8'd1 : 8'd0;
        else if (ovf_set[i] && drop_cnt_q[i] != 8'hFF) drop_cnt_q[i] <= drop_cnt_q[i] + 8'd1;
      end
    end
  end

  always_comb begin
    drop_cnt_os = '0;
    for (int i = 0; i < N_CH; i++) drop_cnt_os[i*8 +: 8] = drop_cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_adc_sample_arbiter.sv
// tb_adc_sample_arbiter: directed checks of capture latency, round-robin
// order, full/overflow handling, trigger divider, reset and timestamp wrap.
// The wrap case uses a second instance with an 8-bit timestamp.
module tb_adc_sample_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tick = 1'b0;
  logic         en = 1'b1;
  logic [3:0]   ready = '0;
  logic [127:0] data = '0;
  logic [15:0]  div = '0;
  logic [3:0]   mask = '0;
  logic [3:0]   trig;
  logic         full = 1'b0;
  logic         wr;
  logic [63:0]  fdata;
  logic         clr = 1'b0;
  logic [3:0]   ovf;
  logic         busy;

  logic         tick_w = 1'b0;
  logic [1:0]   ready_w = '0;
  logic [15:0]  data_w = '0;
  logic [1:0]   trig_w;
  logic         wr_w;
  logic [23:0]  fdata_w;
  logic [1:0]   ovf_w;
  logic         busy_w;

`ifdef ADC_ARB_DROP_CNT_EN
  logic [31:0]  drop_cnt;
  logic [15:0]  drop_cnt_w;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  adc_sample_arbiter dut (
    .fpga_clk_i    (clk),
    .rst_i         (rst),
    .timer_tick_i  (tick),
    .en_i          (en),
    .data_ready_is (ready),
    .data_is       (data),
    .trig_div_i    (div),
    .trig_mask_i   (mask),
    .trig_os       (trig),
    .fifo_full_i   (full),
    .fifo_wr_o     (wr),
    .fifo_data_o   (fdata),
    .ovf_clr_i     (clr),
    .ovf_os        (ovf),
    .busy_o        (busy)
`ifdef ADC_ARB_DROP_CNT_EN
    ,
    .drop_cnt_os   (drop_cnt)
`endif
  );

  adc_sample_arbiter #(.N_CH(2), .DATA_W(8), .TS_W(8)) dut_w (
    .fpga_clk_i    (clk),
    .rst_i         (rst),
    .timer_tick_i  (tick_w),
    .en_i          (1'b1),
    .data_ready_is (ready_w),
    .data_is       (data_w),
    .trig_div_i    (16'd0),
    .trig_mask_i   (2'b00),
    .trig_os       (trig_w),
    .fifo_full_i   (1'b0),
    .fifo_wr_o     (wr_w),
    .fifo_data_o   (fdata_w),
    .ovf_clr_i     (1'b0),
    .ovf_os        (ovf_w),
    .busy_o        (busy_w)
`ifdef ADC_ARB_DROP_CNT_EN
    ,
    .drop_cnt_os   (drop_cnt_w)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
  endtask

  initial begin
    int wcnt;
    int hits;
    logic found;
    logic [63:0] last;
    logic [31:0] s;

    #2;
    chk("rst_wr", 64'(wr), 64'd0);
    chk("rst_data", fdata, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_trig", 64'(trig), 64'd0);
    step(1);
    rst = 1'b0;
    step(2);

    // single channel latency with timestamp 5
    tick = 1'b1;
    step(5);
    tick = 1'b0;
    ready = 4'b0100;
    data[2*32 +: 32] = 32'hCAFE0002;
    step(1);
    ready = '0;
    chk("lat_wr_early", 64'(wr), 64'd0);
    chk("lat_busy", 64'(busy), 64'd1);
    step(1);
    chk("lat_wr", 64'(wr), 64'd1);
    chk("lat_data", fdata, {24'h000005, 8'h02, 32'hCAFE0002});
    step(1);
    chk("lat_wr_done", 64'(wr), 64'd0);
    chk("lat_busy_done", 64'(busy), 64'd0);
    chk("lat_data_hold", fdata, {24'h000005, 8'h02, 32'hCAFE0002});

    // all four at once from pointer 0
    do_reset();
    ready = 4'hF;
    for (int i = 0; i < 4; i++) data[i*32 +: 32] = 32'h100 + 32'(i);
    step(1);
    ready = '0;
    chk("rr_wr_early", 64'(wr), 64'd0);
    for (int i = 0; i < 4; i++) begin
      step(1);
      s = 32'h100 + 32'(i);
      chk("rr_wr", 64'(wr), 64'd1);
      chk("rr_data", fdata, {24'h0, 8'(i), s});
    end
    step(1);
    chk("rr_wr_done", 64'(wr), 64'd0);

    // new sample arriving while its slot is granted
    ready = 4'b1000;
    data[3*32 +: 32] = 32'hAAAA0003;
    step(1);
    data[3*32 +: 32] = 32'hBBBB0003;
    step(1);
    ready = '0;
    chk("fwd_wr_old", 64'(wr), 64'd1);
    chk("fwd_data_old", fdata, {24'h0, 8'h03, 32'hAAAA0003});
    step(1);
    chk("fwd_wr_new", 64'(wr), 64'd1);
    chk("fwd_data_new", fdata, {24'h0, 8'h03, 32'hBBBB0003});
    chk("fwd_ovf", 64'(ovf), 64'd0);
    step(1);
    chk("fwd_wr_done", 64'(wr), 64'd0);

    // FIFO full with overflow on ch1
    do_reset();
    full = 1'b1;
    ready = 4'b0010;
    data[1*32 +: 32] = 32'h1111AAAA;
    step(1);
    data[1*32 +: 32] = 32'h1111BBBB;
    step(1);
    ready = '0;
    chk("full_ovf", 64'(ovf), 64'b0010);
`ifdef ADC_ARB_DROP_CNT_EN
    chk("full_drop_cnt", 64'(drop_cnt), 64'h0000_0100);
`endif
    wcnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (wr) wcnt++;
    end
    chk("full_no_wr", 64'(wcnt), 64'd0);
    chk("full_busy", 64'(busy), 64'd1);
    full = 1'b0;
    wcnt = 0;
    last = '0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (wr) begin
        wcnt++;
        last = fdata;
      end
    end
    chk("full_one_wr", 64'(wcnt), 64'd1);
    chk("full_wr_data", last, {24'h0, 8'h01, 32'h1111AAAA});
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("ovf_clr", 64'(ovf), 64'd0);
`ifdef ADC_ARB_DROP_CNT_EN
    chk("drop_cnt_clr", 64'(drop_cnt), 64'd0);
`endif
    full = 1'b1;
    ready = 4'b0010;
    step(1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    ready = '0;
    chk("ovf_set_wins", 64'(ovf), 64'b0010);
    full = 1'b0;
    step(3);
    clr = 1'b1;
    step(1);
    clr = 1'b0;

    // trigger divider
    div = 16'd9;
    mask = 4'b0101;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step(1);
      if (trig != 4'b0000) found = 1'b1;
    end
    chk("trig_found", 64'(found), 64'd1);
    chk("trig_val", 64'(trig), 64'b0101);
    for (int p = 0; p < 2; p++) begin
      hits = 0;
      for (int i = 0; i < 9; i++) begin
        step(1);
        if (trig != 4'b0000) hits++;
      end
      chk("trig_gap", 64'(hits), 64'd0);
      step(1);
      chk("trig_period", 64'(trig), 64'b0101);
    end
    div = 16'd0;
    hits = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (trig != 4'b0000) hits++;
    end
    chk("trig_off", 64'(hits), 64'd0);

    // reset with three channels pending
    full = 1'b1;
    ready = 4'b0111;
    step(1);
    ready = 4'b0001;
    step(1);
    ready = '0;
    chk("mid_busy", 64'(busy), 64'd1);
    chk("mid_ovf", 64'(ovf), 64'b0001);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_wr", 64'(wr), 64'd0);
    chk("mid_rst_data", fdata, 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_ovf", 64'(ovf), 64'd0);
    chk("mid_rst_trig", 64'(trig), 64'd0);
    step(1);
    rst = 1'b0;
    full = 1'b0;
    wcnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (wr) wcnt++;
    end
    chk("mid_no_wr", 64'(wcnt), 64'd0);

    // timestamp wrap on the 8-bit instance
    tick_w = 1'b1;
    step(255);
    tick_w = 1'b0;
    ready_w = 2'b01;
    data_w[7:0] = 8'hA5;
    step(1);
    ready_w = '0;
    step(1);
    chk("wrap_pre_wr", 64'(wr_w), 64'd1);
    chk("wrap_pre_data", 64'(fdata_w), 64'({8'hFF, 8'h00, 8'hA5}));
    tick_w = 1'b1;
    step(1);
    tick_w = 1'b0;
    ready_w = 2'b10;
    data_w[15:8] = 8'h5A;
    step(1);
    ready_w = '0;
    step(1);
    chk("wrap_post_wr", 64'(wr_w), 64'd1);
    chk("wrap_post_data", 64'(fdata_w), 64'({8'h00, 8'h01, 8'h5A}));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
